i2s_mem_arbiter: RTL and testbench
==================================

# i2s_mem_arbiter

Two-channel memory request arbiter that shares the single memory request/data interface of the wishbone I2S core between a playback channel (the I2S memory controller) and a second requester (capture path or a diagnostic/wave-preload engine). It latches one channel's request, forwards it to the memory side, routes returned words and the completion back to the owning channel, and guards each transfer with a stall timeout. It sits between the requesters and the wishbone slave's memory-side logic.

## Interface
- TIMEOUT, 1024: cycles without `memory_data_strobe` or `request_finished` before a granted transfer is aborted (min 2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rr_enable  in  1  1 = round-robin; 0 = fixed priority, ch0 wins.
- ch0_request, ch1_request  in  1  channel wants a transfer; held high until its finished pulse.
- ch0_size, ch1_size  in  24  words requested; sampled at grant.
- ch0_finished, ch1_finished  out  1  one-cycle completion/abort pulse to owner.
- ch0_data, ch1_data  out  32  registered copy of `memory_data`.
- ch0_strobe, ch1_strobe  out  1  one-cycle word-valid pulse to owner.
- request_data  out  1  memory-side request, high for the whole transfer.
- request_size  out  24  latched size of granted request.
- request_finished  in  1  memory side completed the transfer.
- memory_data  in  32  returned word.
- memory_data_strobe  in  1  `memory_data` valid this cycle.
- grant  out  2  one-hot owner (00 = none).
- word_count  out  24  words delivered in current/last transfer.
- timeout_error  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, GRANT, XFER, RELEASE.
- IDLE: if any `chN_request` is high, choose winner, latch `chN_size` into `request_size`, set `grant`, clear `word_count`, clear timeout counter, go GRANT. Otherwise stay.
- Arbitration: `rr_enable`=0 → ch0 if requesting, else ch1. `rr_enable`=1 → if both request, grant the channel not granted last; single requester always wins. `last` pointer resets to ch1, so ch0 wins the first contested arbitration.
- Zero size: winner with `chN_size`=0 is not forwarded; `request_data` stays 0, `chN_finished` pulses in GRANT, go RELEASE.
- GRANT: assert `request_data`, go XFER.
- XFER: each `memory_data_strobe` → `word_count`+1 (saturating at 2^24−1), data/strobe routed to owner only, timeout counter cleared. `request_finished` → drop `request_data`, pulse owner's `chN_finished`, go RELEASE. Counter reaching TIMEOUT−1 with neither event → drop `request_data`, pulse owner finished and `timeout_error`, go RELEASE.
- Strobe and finished in same XFER cycle: word is delivered and counted, then transfer ends.
- RELEASE: `grant` ← 00, update `last`, go IDLE. Guarantees one idle cycle between transfers.
- Strobes outside XFER are dropped; `chN_strobe` never pulses for a non-owner.
- Owner deasserting `chN_request` mid-transfer has no effect; transfer runs to finished/timeout.

## Timing
- Reset (rst low, asynchronous): state IDLE; `request_data`, `request_size`, `grant`, `word_count`, all `chN_finished`, `chN_strobe`, `chN_data`, `timeout_error` = 0; `last` = ch1. Reset mid-transfer drops `request_data` immediately, no finished pulse.
- Request-to-memory latency: `chN_request` high at edge k (IDLE) → `grant` valid after k, `request_data` high after k+1.
- Data latency: `memory_data_strobe` at edge m → `chN_strobe`/`chN_data` valid after m (1 register stage).
- Finish: `request_finished` at edge f → `chN_finished` high for the cycle after f, `request_data` low the same cycle, `grant` 00 one cycle later, earliest next `request_data` at f+3.
- Timeout: abort on the TIMEOUT-th consecutive silent XFER cycle.

## Test plan
- Single ch0 request, size 4, four strobes with data 0x11..0x44, then finished → ch0_strobe ×4 with matching data, word_count=4, ch0_finished one pulse, ch1 outputs quiet.
- Both request simultaneously, rr_enable=1, back-to-back → grants ch0, ch1, ch0; rr_enable=0 → ch0, ch0, ch0 while ch0 keeps requesting.
- Granted ch1, no strobes, TIMEOUT=16 → request_data drops 16 cycles into XFER, timeout_error and ch1_finished pulse once.
- ch0 size 0 → request_data never asserts, ch0_finished pulses 2 cycles after request.
- Strobe and request_finished on same edge after 2 words → word_count=3, third word delivered, then finished.
- Assert rst low mid-XFER with word_count=5 → all outputs 0 asynchronously; after release, fresh ch1 request is granted normally.

Source files
------------

// File: rtl/i2s_mem_arbiter.sv
// Shares the I2S core's single memory request/data port between two requesters.
// One transfer at a time, with a per-transfer stall timeout and an idle cycle between transfers.
module i2s_mem_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rr_enable_i,
  input  logic        ch0_request_i,
  input  logic        ch1_request_i,
  input  logic [23:0] ch0_size_i,
  input  logic [23:0] ch1_size_i,
  output logic        ch0_finished_o,
  output logic        ch1_finished_o,
  output logic [31:0] ch0_data_o,
  output logic [31:0] ch1_data_o,
  output logic        ch0_strobe_o,
  output logic        ch1_strobe_o,
  output logic        request_data_o,
  output logic [23:0] request_size_o,
  input  logic        request_finished_i,
  input  logic [31:0] memory_data_i,
  input  logic        memory_data_strobe_i,
  output logic [1:0]  grant_o,
  output logic [23:0] word_count_o,
  output logic        timeout_error_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;

  state_t      state_q;
  logic        last_q;          // 1 = ch1 owned the previous transfer
  logic [1:0]  grant_q;
  logic        request_data_q;
  logic [23:0] request_size_q;
  logic [23:0] word_count_q;
  logic [23:0] word_count_d;
  logic [CW-1:0] tmo_q;
  logic        ch0_finished_q, ch1_finished_q;
  logic        ch0_strobe_q, ch1_strobe_q;
  logic [31:0] ch0_data_q, ch1_data_q;
  logic        timeout_error_q;
  logic        pick_ch1_d;

  always_comb begin
    pick_ch1_d = ~ch0_request_i;
    if (rr_enable_i && ch0_request_i && ch1_request_i) begin
      pick_ch1_d = ~last_q;
    end
    word_count_d = (word_count_q == 24'hFF_FFFF) ? word_count_q : word_count_q + 24'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      last_q          <= 1'b1;
      grant_q         <= 2'b00;
      request_data_q  <= 1'b0;
      request_size_q  <= 24'd0;
      word_count_q    <= 24'd0;
      tmo_q           <= '0;
      ch0_finished_q  <= 1'b0;
      ch1_finished_q  <= 1'b0;
      ch0_strobe_q    <= 1'b0;
      ch1_strobe_q    <= 1'b0;
      ch0_data_q      <= 32'd0;
      ch1_data_q      <= 32'd0;
      timeout_error_q <= 1'b0;
    end else begin
      ch0_finished_q  <= 1'b0;
      ch1_finished_q  <= 1'b0;
      ch0_strobe_q    <= 1'b0;
      ch1_strobe_q    <= 1'b0;
      timeout_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ch0_request_i || ch1_request_i) begin
            grant_q        <= pick_ch1_d ? 2'b10 : 2'b01;
            request_size_q <= pick_ch1_d ? ch1_size_i : ch0_size_i;
            word_count_q   <= 24'd0;
            tmo_q          <= '0;
            state_q        <= GRANT;
          end
        end
        GRANT: begin
          if (request_size_q == 24'd0) begin
            ch0_finished_q <= grant_q[0];
            ch1_finished_q <= grant_q[1];
            state_q        <= RELEASE;
          end else begin
            request_data_q <= 1'b1;
            state_q        <= XFER;
          end
        end
        XFER: begin
          if (memory_data_strobe_i) begin
            word_count_q <= word_count_d;
            tmo_q        <= '0;
            if (grant_q[1]) begin
              ch1_strobe_q <= 1'b1;
              ch1_data_q   <= memory_data_i;
            end else begin
              ch0_strobe_q <= 1'b1;
              ch0_data_q   <= memory_data_i;
            end
          end
          // A word arriving with the completion is still delivered above.
          if (request_finished_i) begin
            request_data_q <= 1'b0;
            ch0_finished_q <= grant_q[0];
            ch1_finished_q <= grant_q[1];
            state_q        <= RELEASE;
          end else if (!memory_data_strobe_i) begin
            if (tmo_q == TMO_LAST) begin
              request_data_q  <= 1'b0;
              ch0_finished_q  <= grant_q[0];
              ch1_finished_q  <= grant_q[1];
              timeout_error_q <= 1'b1;
              state_q         <= RELEASE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        RELEASE: begin
          grant_q <= 2'b00;
          last_q  <= grant_q[1];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch0_finished_o  = ch0_finished_q;
  assign ch1_finished_o  = ch1_finished_q;
  assign ch0_data_o      = ch0_data_q;
  assign ch1_data_o      = ch1_data_q;
  assign ch0_strobe_o    = ch0_strobe_q;
  assign ch1_strobe_o    = ch1_strobe_q;
  assign request_data_o  = request_data_q;
  assign request_size_o  = request_size_q;
  assign grant_o         = grant_q;
  assign word_count_o    = word_count_q;
  assign timeout_error_o = timeout_error_q;

endmodule

// File: tb/tb_i2s_mem_arbiter.sv
// Directed bench for i2s_mem_arbiter with hand-computed expectations (TIMEOUT = 16).
module tb_i2s_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rr_enable;
  logic        ch0_req, ch1_req;
  logic [23:0] ch0_size, ch1_size;
  logic        ch0_fin, ch1_fin;
  logic [31:0] ch0_dat, ch1_dat;
  logic        ch0_stb, ch1_stb;
  logic        req_data;
  logic [23:0] req_size;
  logic        req_fin;
  logic [31:0] mem_data;
  logic        mem_stb;
  logic [1:0]  grant;
  logic [23:0] word_count;
  logic        tmo_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  i2s_mem_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rr_enable_i(rr_enable),
    .ch0_request_i(ch0_req), .ch1_request_i(ch1_req),
    .ch0_size_i(ch0_size), .ch1_size_i(ch1_size),
    .ch0_finished_o(ch0_fin), .ch1_finished_o(ch1_fin),
    .ch0_data_o(ch0_dat), .ch1_data_o(ch1_dat),
    .ch0_strobe_o(ch0_stb), .ch1_strobe_o(ch1_stb),
    .request_data_o(req_data), .request_size_o(req_size),
    .request_finished_i(req_fin), .memory_data_i(mem_data),
    .memory_data_strobe_i(mem_stb), .grant_o(grant),
    .word_count_o(word_count), .timeout_error_o(tmo_err)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rr_enable = 1'b1; ch0_req = 1'b0; ch1_req = 1'b0;
    ch0_size = 24'd0; ch1_size = 24'd0; req_fin = 1'b0; mem_data = 32'd0; mem_stb = 1'b0;
    tick(); tick();
    checks++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant); else passed++;
    checks++; if (req_data !== 1'b0) $display("FAIL reset_req_data got %b want 0", req_data); else passed++;
    checks++; if (word_count !== 24'd0 || req_size !== 24'd0) $display("FAIL reset_counts got wc=%0d size=%0d want 0/0", word_count, req_size); else passed++;
    checks++; if ({ch0_fin, ch1_fin, ch0_stb, ch1_stb, tmo_err} !== 5'b0) $display("FAIL reset_pulses got %b want 00000", {ch0_fin, ch1_fin, ch0_stb, ch1_stb, tmo_err}); else passed++;
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] exp;
    ch0_req = 1'b1; ch0_size = 24'd4;
    tick();
    checks++; if (grant !== 2'b01 || req_size !== 24'd4 || req_data !== 1'b0) $display("FAIL single_grant got g=%b size=%0d rd=%b want 01/4/0", grant, req_size, req_data); else passed++;
    tick();
    checks++; if (req_data !== 1'b1) $display("FAIL single_req_data got %b want 1", req_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      mem_stb = 1'b1; mem_data = exp;
      tick();
      checks++; if (ch0_stb !== 1'b1 || ch0_dat !== exp || ch1_stb !== 1'b0) $display("FAIL single_word%0d got stb0=%b dat=%h stb1=%b want 1/%h/0", i, ch0_stb, ch0_dat, ch1_stb, exp); else passed++;
    end
    mem_stb = 1'b0; req_fin = 1'b1;
    tick();
    checks++; if (ch0_fin !== 1'b1 || ch1_fin !== 1'b0 || req_data !== 1'b0 || word_count !== 24'd4) $display("FAIL single_finish got f0=%b f1=%b rd=%b wc=%0d want 1/0/0/4", ch0_fin, ch1_fin, req_data, word_count); else passed++;
    checks++; if (ch1_dat !== 32'd0) $display("FAIL single_ch1_quiet got %h want 0", ch1_dat); else passed++;
    req_fin = 1'b0; ch0_req = 1'b0;
    tick();
    checks++; if (ch0_fin !== 1'b0 || grant !== 2'b00) $display("FAIL single_release got f0=%b g=%b want 0/00", ch0_fin, grant); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr [3];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
    // Fresh reset so the last-owner pointer starts at ch1.
    rst_n = 1'b0; #2 rst_n = 1'b1;
    tick();
    ch0_req = 1'b1; ch1_req = 1'b1; ch0_size = 24'd2; ch1_size = 24'd3;
    for (int pass = 0; pass < 2; pass++) begin
      rr_enable = (pass == 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (grant !== ((pass == 0) ? exp_rr[i] : 2'b01)) $display("FAIL b2b_rr%0d_xfer%0d got %b want %b", 1 - pass, i, grant, (pass == 0) ? exp_rr[i] : 2'b01);
        else passed++;
        tick();
        req_fin = 1'b1;
        tick();
        req_fin = 1'b0;
        tick();
      end
    end
    ch0_req = 1'b0; ch1_req = 1'b0; rr_enable = 1'b1;
  endtask

  task automatic test_timeout();
    ch1_req = 1'b1; ch1_size = 24'd7;
    tick();
    checks++; if (grant !== 2'b10) $display("FAIL tmo_grant got %b want 10", grant); else passed++;
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (req_data !== 1'b1 || tmo_err !== 1'b0) $display("FAIL tmo_early got rd=%b err=%b want 1/0", req_data, tmo_err); else passed++;
    tick();
    checks++; if (req_data !== 1'b0 || tmo_err !== 1'b1 || ch1_fin !== 1'b1 || ch0_fin !== 1'b0) $display("FAIL tmo_abort got rd=%b err=%b f1=%b f0=%b want 0/1/1/0", req_data, tmo_err, ch1_fin, ch0_fin); else passed++;
    ch1_req = 1'b0;
    tick();
    checks++; if (tmo_err !== 1'b0 || ch1_fin !== 1'b0 || grant !== 2'b00) $display("FAIL tmo_single_pulse got err=%b f1=%b g=%b want 0/0/00", tmo_err, ch1_fin, grant); else passed++;
  endtask

  task automatic test_zero_size();
    ch0_req = 1'b1; ch0_size = 24'd0;
    tick();
    checks++; if (grant !== 2'b01 || ch0_fin !== 1'b0 || req_data !== 1'b0) $display("FAIL zero_grant got g=%b f0=%b rd=%b want 01/0/0", grant, ch0_fin, req_data); else passed++;
    tick();
    checks++; if (ch0_fin !== 1'b1 || req_data !== 1'b0) $display("FAIL zero_finish got f0=%b rd=%b want 1/0", ch0_fin, req_data); else passed++;
    ch0_req = 1'b0;
    tick();
    checks++; if (ch0_fin !== 1'b0 || req_data !== 1'b0 || grant !== 2'b00) $display("FAIL zero_release got f0=%b rd=%b g=%b want 0/0/00", ch0_fin, req_data, grant); else passed++;
  endtask

  task automatic test_strobe_finish();
    ch0_req = 1'b1; ch0_size = 24'd3;
    tick(); tick();
    mem_stb = 1'b1;
    mem_data = 32'hA1; tick();
    mem_data = 32'hA2; tick();
    mem_data = 32'hA3; req_fin = 1'b1;
    tick();
    checks++; if (ch0_stb !== 1'b1 || ch0_dat !== 32'hA3 || word_count !== 24'd3) $display("FAIL sf_word got stb=%b dat=%h wc=%0d want 1/a3/3", ch0_stb, ch0_dat, word_count); else passed++;
    checks++; if (ch0_fin !== 1'b1 || req_data !== 1'b0) $display("FAIL sf_finish got f0=%b rd=%b want 1/0", ch0_fin, req_data); else passed++;
    mem_stb = 1'b0; req_fin = 1'b0; ch0_req = 1'b0;
    tick();
    checks++; if (ch0_stb !== 1'b0 || word_count !== 24'd3) $display("FAIL sf_after got stb=%b wc=%0d want 0/3", ch0_stb, word_count); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    ch1_req = 1'b1; ch1_size = 24'd9;
    tick(); tick();
    mem_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_data = 32'hC0 + i;
      tick();
    end
    mem_stb = 1'b0;
    checks++; if (word_count !== 24'd5 || req_data !== 1'b1) $display("FAIL mid_pre got wc=%0d rd=%b want 5/1", word_count, req_data); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_data !== 1'b0 || grant !== 2'b00 || word_count !== 24'd0 || ch1_stb !== 1'b0 || ch1_dat !== 32'd0 || ch1_fin !== 1'b0) $display("FAIL mid_async got rd=%b g=%b wc=%0d stb1=%b dat1=%h f1=%b want all 0", req_data, grant, word_count, ch1_stb, ch1_dat, ch1_fin); else passed++;
    #2 rst_n = 1'b1;
    tick();
    checks++; if (grant !== 2'b10 || req_size !== 24'd9) $display("FAIL mid_regrant got g=%b size=%0d want 10/9", grant, req_size); else passed++;
    tick();
    checks++; if (req_data !== 1'b1) $display("FAIL mid_req_data got %b want 1", req_data); else passed++;
    req_fin = 1'b1;
    tick();
    checks++; if (ch1_fin !== 1'b1 || ch0_fin !== 1'b0) $display("FAIL mid_finish got f1=%b f0=%b want 1/0", ch1_fin, ch0_fin); else passed++;
    req_fin = 1'b0; ch1_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_zero_size();
    test_strobe_finish();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
